// File: rtl/vga_capture.sv
// vga_capture: rebuilds pixel coordinates from a same-clock VGA stream and
// measures the active-area geometry. It declares lock once the geometry is
// stable and produces a 16-bit signature of each frame's active pixels.
// Optional feature macro: VGA_CAPTURE_CHANGE_EN builds a previous-signature
// register and drives sig_changed. Without it, sig_changed is tied to 0.
// sig_valid is a one-cycle strobe with no backpressure. frame_sig,
// h_active, v_active, sig_changed and locked are all new on that cycle and
// hold until the next strobe.
module vga_capture #(
    parameter int SYNC_ACTIVE_HIGH = 1,
    parameter int LOCK_FRAMES      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [5:0]  colour,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        pixel_valid,
    output logic [15:0] frame_sig,
    output logic [9:0]  h_active,
    output logic [9:0]  v_active,
    output logic        sig_valid,
    output logic        locked,
    output logic        sig_changed,
    output logic [1:0]  dbg_lock_state
);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [9:0] CNT_MAX  = 10'h3FF;
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_FRAMES - 1);

    function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [5:0] c);
        return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {10'b0, c};
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + 10'd1;
    endfunction

    // sync levels normalised so that 1 always means "in the pulse"
    logic w_hs_act, w_vs_act, w_hs_edge, w_vs_edge, w_pix;
    logic r_hs_q, r_vs_q;

    logic [9:0]  r_x_cnt, r_y_cnt, r_line_len;
    logic [15:0] r_sig;
    logic        r_started;

    logic        w_line_close, w_close;
    logic [9:0]  w_x_base, w_y_closed, w_y_base, w_len_closed;
    logic [15:0] w_sig_base;

    logic [9:0]  r_x_pos, r_y_pos;
    logic        r_pixel_valid;
    logic [15:0] r_frame_sig;
    logic [9:0]  r_h_active, r_v_active;
    logic        r_sig_valid;

    logic [1:0]  r_state, w_state_next;
    logic [9:0]  r_cand_h, r_cand_v;
    logic [7:0]  r_match_cnt;
    logic        w_geom_nz, w_geom_eq, w_lock_reach;

    assign w_hs_act  = (SYNC_ACTIVE_HIGH != 0) ? hsync : ~hsync;
    assign w_vs_act  = (SYNC_ACTIVE_HIGH != 0) ? vsync : ~vsync;
    assign w_hs_edge = w_hs_act & ~r_hs_q;
    assign w_vs_edge = w_vs_act & ~r_vs_q;
    assign w_pix     = ~blank;

    // Line close happens before frame close, so a coincident vsync edge
    // reports the geometry that includes the line ending on this cycle.
    assign w_line_close = w_hs_edge & (r_x_cnt != 10'd0);
    assign w_y_closed   = w_line_close ? sat_inc(r_y_cnt) : r_y_cnt;
    assign w_len_closed = w_line_close ? r_x_cnt : r_line_len;
    assign w_x_base     = w_hs_edge ? 10'd0 : r_x_cnt;
    assign w_y_base     = w_vs_edge ? 10'd0 : w_y_closed;
    assign w_sig_base   = w_vs_edge ? 16'hFFFF : r_sig;
    assign w_close      = w_vs_edge & r_started;

    assign w_geom_nz    = (w_len_closed != 10'd0) && (w_y_closed != 10'd0);
    assign w_geom_eq    = (w_len_closed == r_cand_h) && (w_y_closed == r_cand_v);
    assign w_lock_reach = ((r_match_cnt + 8'd1) >= LOCK_LAST);

    // one-cycle delay of the sync levels for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hs_q <= 1'b0;
            r_vs_q <= 1'b0;
        end else begin
            r_hs_q <= w_hs_act;
            r_vs_q <= w_vs_act;
        end
    end

    // pixel/line counters and running signature
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_cnt    <= 10'd0;
            r_y_cnt    <= 10'd0;
            r_line_len <= 10'd0;
            r_sig      <= 16'hFFFF;
            r_started  <= 1'b0;
        end else begin
            r_x_cnt    <= w_pix ? sat_inc(w_x_base) : w_x_base;
            r_y_cnt    <= w_y_base;
            r_line_len <= w_vs_edge ? 10'd0 : w_len_closed;
            r_sig      <= w_pix ? sig_step(w_sig_base, colour) : w_sig_base;
            r_started  <= r_started | w_vs_edge;
        end
    end

    // registered pixel coordinates, gated until the first vsync edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_pos       <= 10'd0;
            r_y_pos       <= 10'd0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel_valid <= (r_started | w_vs_edge) & w_pix;
            if (w_pix) begin
                r_x_pos <= w_x_base;
                r_y_pos <= w_y_base;
            end
        end
    end

    // frame close: latch signature and geometry, pulse the strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_sig <= 16'h0000;
            r_h_active  <= 10'd0;
            r_v_active  <= 10'd0;
            r_sig_valid <= 1'b0;
        end else begin
            r_sig_valid <= w_close;
            if (w_close) begin
                r_frame_sig <= r_sig;
                r_h_active  <= w_len_closed;
                r_v_active  <= w_y_closed;
            end
        end
    end

    // lock FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_SEARCH;
        else        r_state <= w_state_next;
    end

    // lock FSM next state, evaluated only at frame close
    always_comb begin
        w_state_next = r_state;
        if (w_close) begin
            case (r_state)
                S_SEARCH: if (w_geom_nz) w_state_next = S_CHECK;
                S_CHECK:  if (w_geom_nz && w_geom_eq && w_lock_reach) w_state_next = S_LOCKED;
                S_LOCKED: if (!(w_geom_nz && w_geom_eq)) w_state_next = S_SEARCH;
                default:  w_state_next = S_SEARCH;
            endcase
        end
    end

    // lock FSM outputs
    always_comb begin
        locked         = (r_state == S_LOCKED);
        dbg_lock_state = r_state;
    end

    // candidate geometry and match counter for the lock FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cand_h    <= 10'd0;
            r_cand_v    <= 10'd0;
            r_match_cnt <= 8'd0;
        end else if (w_close) begin
            case (r_state)
                S_SEARCH: begin
                    if (w_geom_nz) begin
                        r_cand_h    <= w_len_closed;
                        r_cand_v    <= w_y_closed;
                        r_match_cnt <= 8'd0;
                    end
                end
                S_CHECK: begin
                    if (w_geom_nz && w_geom_eq) begin
                        r_match_cnt <= r_match_cnt + 8'd1;
                    end else begin
                        r_cand_h    <= w_len_closed;
                        r_cand_v    <= w_y_closed;
                        r_match_cnt <= 8'd0;
                    end
                end
                default: r_match_cnt <= 8'd0;
            endcase
        end
    end

`ifdef VGA_CAPTURE_CHANGE_EN
    logic [15:0] r_prev_sig;
    logic        r_have_prev;
    logic        r_sig_changed;

    // compare each new signature with the previous one; the first is always "changed"
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_sig    <= 16'h0000;
            r_have_prev   <= 1'b0;
            r_sig_changed <= 1'b0;
        end else begin
            r_sig_changed <= w_close & (~r_have_prev | (r_sig != r_prev_sig));
            if (w_close) begin
                r_prev_sig  <= r_sig;
                r_have_prev <= 1'b1;
            end
        end
    end

    assign sig_changed = r_sig_changed;
`else
    assign sig_changed = 1'b0;
`endif

    assign x_pos       = r_x_pos;
    assign y_pos       = r_y_pos;
    assign pixel_valid = r_pixel_valid;
    assign frame_sig   = r_frame_sig;
    assign h_active    = r_h_active;
    assign v_active    = r_v_active;
    assign sig_valid   = r_sig_valid;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: drives whole frames described as lists of line lengths
// and predicts coordinates, strobes, signatures and lock status frame by
// frame.
module tb_vga_capture;

    localparam int LOCK_FRAMES = 2;

    typedef struct {
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
    } pix_t;

    typedef struct {
        int          cyc;
        logic [15:0] sig;
        int          h;
        int          v;
        logic        lk;
        logic        chg;
    } stb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        blank = 1'b1;
    logic [5:0]  colour = 6'd0;
    logic [9:0]  x_pos, y_pos, h_active, v_active;
    logic        pixel_valid, sig_valid, locked, sig_changed;
    logic [15:0] frame_sig;
    logic [1:0]  dbg_lock_state;

    vga_capture #(.SYNC_ACTIVE_HIGH(1), .LOCK_FRAMES(LOCK_FRAMES)) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .blank(blank),
        .colour(colour), .x_pos(x_pos), .y_pos(y_pos), .pixel_valid(pixel_valid),
        .frame_sig(frame_sig), .h_active(h_active), .v_active(v_active),
        .sig_valid(sig_valid), .locked(locked), .sig_changed(sig_changed),
        .dbg_lock_state(dbg_lock_state)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // model state
    pix_t        pix_q[$];
    stb_t        stb_q[$];
    bit          m_started, m_seen_vs, m_defer_pend, m_first;
    int          m_carry;
    logic [15:0] m_fsig, m_prev;
    int          m_fh, m_fv;
    int          m_ls, m_ch, m_cv, m_cnt;
    logic [15:0] m_cur_sig;
    int          m_cur_h, m_cur_v;
    logic        m_cur_lk;
    int          lens[0:1099];
    int          cmode;
    logic [5:0]  cfix;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sig_ref(input logic [15:0] s, input logic [5:0] c);
        logic [16:0] sh;
        sh = {s, 1'b0};
        return sh[15:0] ^ ((s >= 16'h8000) ? 16'h1021 : 16'h0000) ^ {10'b0, c};
    endfunction

    function automatic int min1023(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    function automatic logic [5:0] colour_for(input int l, input int i);
        case (cmode)
            1:       return cfix;
            2:       return 6'((i * 3 + l * 5) & 63);
            3:       return 6'(((i * 3 + l * 5) & 63) ^ ((l == 0 && i == 0) ? 1 : 0));
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic step(input logic hs, input logic vs, input logic bl, input logic [5:0] c);
        @(posedge clk);
        #1;
        hsync = hs; vsync = vs; blank = bl; colour = c;
    endtask

    // frame-level rules applied when a frame closes
    task automatic model_close(output logic lk, output logic chg);
        bit ok, eq;
        ok = (m_fh != 0) && (m_fv != 0);
        eq = (m_fh == m_ch) && (m_fv == m_cv);
        if (m_ls == 0) begin
            if (ok) begin m_ch = m_fh; m_cv = m_fv; m_cnt = 0; m_ls = 1; end
        end else if (m_ls == 1) begin
            if (ok && eq) begin
                m_cnt++;
                if (m_cnt >= LOCK_FRAMES - 1) m_ls = 2;
            end else begin
                m_ch = m_fh; m_cv = m_fv; m_cnt = 0;
            end
        end else begin
            if (!(ok && eq)) m_ls = 0;
        end
        lk = (m_ls == 2);
`ifdef VGA_CAPTURE_CHANGE_EN
        chg = m_first ? 1'b1 : (m_fsig != m_prev);
        m_prev = m_fsig;
        m_first = 1'b0;
`else
        chg = 1'b0;
`endif
    endtask

    // one frame: vsync pulse, then nl lines each ending in an hsync pulse
    task automatic send_frame(input int nl, input bit defer_last);
        stb_t        e;
        pix_t        p;
        logic [15:0] sig;
        logic [5:0]  c;
        int          act, last_len, eff;
        step(m_defer_pend, 1'b1, 1'b1, 6'd0);
        if (m_started) begin
            e.cyc = cyc + 1; e.sig = m_fsig; e.h = m_fh; e.v = m_fv;
            model_close(e.lk, e.chg);
            stb_q.push_back(e);
        end
        if (m_defer_pend) m_carry = 0;
        m_defer_pend = 1'b0;
        m_started = 1'b1;
        m_seen_vs = 1'b1;
        step(1'b0, 1'b1, 1'b1, 6'd0);
        step(1'b0, 1'b0, 1'b1, 6'd0);
        sig = 16'hFFFF; act = 0; last_len = 0;
        for (int l = 0; l < nl; l++) begin
            step(1'b0, 1'b0, 1'b1, 6'd0);
            eff = m_carry;
            for (int i = 0; i < lens[l]; i++) begin
                c = colour_for(l, i);
                step(1'b0, 1'b0, 1'b0, c);
                p.cyc = cyc + 1; p.x = 10'(min1023(eff)); p.y = 10'(min1023(act));
                pix_q.push_back(p);
                sig = sig_ref(sig, c);
                eff++;
            end
            step(1'b0, 1'b0, 1'b1, 6'd0);
            if (defer_last && l == nl - 1) m_defer_pend = 1'b1;
            else step(1'b1, 1'b0, 1'b1, 6'd0);
            m_carry = 0;
            if (eff > 0) begin act++; last_len = min1023(eff); end
        end
        step(1'b0, 1'b0, 1'b1, 6'd0);
        step(1'b0, 1'b0, 1'b1, 6'd0);
        m_fsig = sig; m_fh = last_len; m_fv = min1023(act);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0; blank = 1'b1; colour = 6'd0;
        repeat (3) step(1'b0, 1'b0, 1'b1, 6'd0);
        rst_n = 1'b1;
        pix_q.delete(); stb_q.delete();
        m_started = 0; m_seen_vs = 0; m_defer_pend = 0; m_first = 1; m_carry = 0;
        m_prev = 16'h0; m_ls = 0; m_ch = 0; m_cv = 0; m_cnt = 0;
        m_cur_sig = 16'h0; m_cur_h = 0; m_cur_v = 0; m_cur_lk = 1'b0;
        @(negedge clk);
        chk("rst_frame_sig", 32'(frame_sig), 32'h0);
        chk("rst_h_active", 32'(h_active), 32'h0);
        chk("rst_v_active", 32'(v_active), 32'h0);
        chk("rst_sig_valid", 32'(sig_valid), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_pixel_valid", 32'(pixel_valid), 32'h0);
        chk("rst_x_pos", 32'(x_pos), 32'h0);
        chk("rst_y_pos", 32'(y_pos), 32'h0);
        chk("rst_sig_changed", 32'(sig_changed), 32'h0);
        chk_en = 1'b1;
    endtask

    // scoreboard: every cycle, compare outputs against the queued predictions
    always @(negedge clk) begin
        if (chk_en) begin
            while (pix_q.size() > 0 && pix_q[0].cyc < cyc) begin
                n_checks++; n_errors++;
                $display("FAIL pixel_missing: got none expected pixel due at cycle %0d", pix_q[0].cyc);
                void'(pix_q.pop_front());
            end
            while (stb_q.size() > 0 && stb_q[0].cyc < cyc) begin
                n_checks++; n_errors++;
                $display("FAIL strobe_missing: got none expected strobe due at cycle %0d", stb_q[0].cyc);
                void'(stb_q.pop_front());
            end
            if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
                chk("pixel_valid", 32'(pixel_valid), 32'h1);
                chk("x_pos", 32'(x_pos), 32'(pix_q[0].x));
                chk("y_pos", 32'(y_pos), 32'(pix_q[0].y));
                void'(pix_q.pop_front());
            end else begin
                chk("pixel_valid_idle", 32'(pixel_valid), 32'h0);
            end
            if (stb_q.size() > 0 && stb_q[0].cyc == cyc) begin
                chk("sig_valid", 32'(sig_valid), 32'h1);
                chk("sig_changed_strobe", 32'(sig_changed), 32'(stb_q[0].chg));
                m_cur_sig = stb_q[0].sig; m_cur_h = stb_q[0].h;
                m_cur_v = stb_q[0].v; m_cur_lk = stb_q[0].lk;
                void'(stb_q.pop_front());
            end else begin
                chk("sig_valid_idle", 32'(sig_valid), 32'h0);
                chk("sig_changed_idle", 32'(sig_changed), 32'h0);
            end
            chk("frame_sig", 32'(frame_sig), 32'(m_cur_sig));
            chk("h_active", 32'(h_active), 32'(m_cur_h));
            chk("v_active", 32'(v_active), 32'(m_cur_v));
            chk("locked", 32'(locked), 32'(m_cur_lk));
        end
    end

    task automatic good_frame();
        cmode = 2;
        for (int l = 0; l < 8; l++) lens[l] = 12;
        send_frame(8, 1'b0);
    endtask

    task automatic random_lens(input int nl);
        for (int l = 0; l < nl; l++)
            lens[l] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
    endtask

    initial begin
        automatic int nl;
        do_reset();

        // pixels before any sync count into the first line's x
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 6'($urandom_range(0, 63)));
            m_carry++;
        end
        step(1'b0, 1'b0, 1'b1, 6'd0);
        cmode = 0;
        for (int l = 0; l < 4; l++) lens[l] = 5;
        send_frame(4, 1'b0);

        // single-pixel frames with hand-computed signatures
        cmode = 1; cfix = 6'h00; lens[0] = 1;
        send_frame(1, 1'b0);
        cfix = 6'h3C;
        send_frame(1, 1'b0);
        chk("lit_sig_colour00", 32'(frame_sig), 32'hEFDF);
        chk("lit_h_single", 32'(h_active), 32'd1);
        chk("lit_v_single", 32'(v_active), 32'd1);
        chk("lit_model_sig3c", 32'(m_fsig), 32'hEFE3);

        // blank-only frame with a few empty lines
        for (int l = 0; l < 3; l++) lens[l] = 0;
        send_frame(3, 1'b0);
        chk("lit_sig_colour3c", 32'(frame_sig), 32'hEFE3);

        // lock acquisition, loss on a short frame, and recovery
        good_frame();
        chk("lit_blank_sig", 32'(frame_sig), 32'hFFFF);
        chk("lit_blank_v", 32'(v_active), 32'd0);
        chk("lit_blank_locked", 32'(locked), 32'd0);
        good_frame();
        good_frame();
        chk("lit_locked_second", 32'(locked), 32'd1);
        chk("lit_h_good", 32'(h_active), 32'd12);
        chk("lit_v_good", 32'(v_active), 32'd8);
        good_frame();
        cmode = 2;
        for (int l = 0; l < 7; l++) lens[l] = 12;
        send_frame(7, 1'b0);
        good_frame();
        chk("lit_unlock_short", 32'(locked), 32'd0);
        chk("lit_v_short", 32'(v_active), 32'd7);
        good_frame();
        good_frame();
        chk("lit_relock", 32'(locked), 32'd1);

        // one changed pixel with unchanged geometry
        cmode = 3;
        for (int l = 0; l < 8; l++) lens[l] = 12;
        send_frame(8, 1'b0);
        good_frame();

        // last hsync edge coincides with the next vsync edge
        cmode = 0;
        random_lens(3); lens[2] = 9;
        send_frame(3, 1'b1);
        random_lens(2);
        send_frame(2, 1'b0);
        chk("lit_defer_h", 32'(h_active), 32'd9);

        // x and y saturation
        lens[0] = 1030;
        send_frame(1, 1'b0);
        for (int l = 0; l < 1030; l++) lens[l] = 1;
        send_frame(1030, 1'b0);
        chk("lit_xsat_h", 32'(h_active), 32'd1023);
        lens[0] = 4;
        send_frame(1, 1'b0);
        chk("lit_ysat_v", 32'(v_active), 32'd1023);

        // random frames
        for (int f = 0; f < 8; f++) begin
            nl = int'($urandom_range(0, 6));
            random_lens(nl);
            send_frame(nl, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
        end
        random_lens(3);
        send_frame(3, 1'b0);

        // reset with a frame open: next vsync must not strobe
        do_reset();
        good_frame();
        good_frame();
        good_frame();
        send_frame(0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b1, 6'd0);
        @(negedge clk);
        chk("pix_queue_drained", 32'(pix_q.size()), 32'd0);
        chk("stb_queue_drained", 32'(stb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

endmodule
